msrv32_wb_arbiter: RTL and testbench

- Shares the single write port of the integer register file between N_SRC writeback producers (ALU, load unit, CSR unit).
- Each producer gets a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains one buffer per cycle into a registered write port (wr_en_out / rd_addr_out / rd_out) that drives the register file.
- Publishes a pending-write mask that decode uses for RAW stall decisions. Same-register write order is preserved.

---
 rtl/msrv32_pkg.sv | 18 +
 rtl/msrv32_rr_arbiter.sv | 29 ++
 rtl/msrv32_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_msrv32_wb_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared core types: register-file geometry and the writeback request payload.
package msrv32_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction

endpackage

// File: rtl/msrv32_rr_arbiter.sv
// N-way round-robin arbiter: grants the first requester at or after ptr, wrapping.
module msrv32_rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!any_grant && req[IDX_W'(idx)]) begin
                grant[IDX_W'(idx)] = 1'b1;
                grant_idx          = IDX_W'(idx);
                any_grant          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msrv32_wb_arbiter.sv
// Shares the register-file write port between N_SRC writeback producers through
// one-entry buffers, round-robin drain and same-register ordering.
module msrv32_wb_arbiter #(
    parameter int unsigned N_SRC      = 3,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic [N_SRC-1:0]            src_valid_in,
    output logic [N_SRC-1:0]            src_ready_out,
    input  logic [N_SRC*REG_ADDR_W-1:0] src_rd_addr_in,
    input  logic [N_SRC*XLEN-1:0]       src_data_in,
    output logic                        wr_en_out,
    output logic [REG_ADDR_W-1:0]       rd_addr_out,
    output logic [XLEN-1:0]             rd_out,
    output logic [31:0]                 pend_mask_out,
    output logic                        idle_out
);

    import msrv32_pkg::*;

    localparam int unsigned PTR_W = $clog2(N_SRC);

    wb_req_t          entry_q [N_SRC];
    wb_req_t          out_q;
    wb_req_t          granted;
    logic [PTR_W-1:0] ptr_q;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] grant;
    logic [PTR_W-1:0] grant_idx;
    logic             any_grant;
    logic [N_SRC-1:0] ready;
    logic [31:0]      pend;

    always_comb begin
        req = '0;
        for (int i = 0; i < N_SRC; i++) req[i] = entry_q[i].valid;
    end

    msrv32_rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (PTR_W)
    ) u_rr (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign granted = entry_q[grant_idx];

    // Accept when the slot frees this cycle and no older write to the same rd is
    // still waiting; lower indices win same-cycle ties on a shared rd.
    always_comb begin
        logic conflict;
        ready    = '0;
        conflict = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            conflict = 1'b0;
            if (src_rd_addr_in[i*REG_ADDR_W +: REG_ADDR_W] != '0) begin
                for (int j = 0; j < N_SRC; j++) begin
                    if (j != i && entry_q[j].valid && !grant[j] &&
                        entry_q[j].rd == src_rd_addr_in[i*REG_ADDR_W +: REG_ADDR_W])
                        conflict = 1'b1;
                end
                for (int k = 0; k < i; k++) begin
                    if (src_valid_in[k] && ready[k] &&
                        src_rd_addr_in[k*REG_ADDR_W +: REG_ADDR_W] ==
                        src_rd_addr_in[i*REG_ADDR_W +: REG_ADDR_W])
                        conflict = 1'b1;
                end
            end
            ready[i] = (!entry_q[i].valid || grant[i]) && !conflict;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < N_SRC; i++) entry_q[i] <= '0;
            out_q <= '0;
            ptr_q <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (src_valid_in[i] && ready[i]) begin
                    entry_q[i] <= '{valid: 1'b1,
                                    rd:    src_rd_addr_in[i*REG_ADDR_W +: REG_ADDR_W],
                                    data:  src_data_in[i*XLEN +: XLEN]};
                end else if (grant[i]) begin
                    entry_q[i].valid <= 1'b0;
                end
            end
            // rd=0 grants are consumed silently; address/data hold when idle
            if (any_grant) begin
                out_q.valid <= (granted.rd != '0);
                out_q.rd    <= granted.rd;
                out_q.data  <= granted.data;
                ptr_q       <= (grant_idx == PTR_W'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                out_q.valid <= 1'b0;
            end
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (entry_q[i].valid && entry_q[i].rd != '0) pend = pend | rd_onehot(entry_q[i].rd);
        end
        if (out_q.valid) pend = pend | rd_onehot(out_q.rd);
    end

    assign src_ready_out = ready;
    assign wr_en_out     = out_q.valid;
    assign rd_addr_out   = out_q.rd;
    assign rd_out        = out_q.data;
    assign pend_mask_out = pend;
    assign idle_out      = !(|req) && !out_q.valid;

endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
// Bench for msrv32_wb_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_msrv32_wb_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned XW = 32;
    localparam int unsigned AW = 5;

    logic            clk_in = 1'b0;
    logic            reset_in;
    logic [N-1:0]    src_valid_in;
    logic [N-1:0]    src_ready_out;
    logic [N*AW-1:0] src_rd_addr_in;
    logic [N*XW-1:0] src_data_in;
    logic            wr_en_out;
    logic [AW-1:0]   rd_addr_out;
    logic [XW-1:0]   rd_out;
    logic [31:0]     pend_mask_out;
    logic            idle_out;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model state
    logic          m_valid [N];
    logic [AW-1:0] m_rd    [N];
    logic [XW-1:0] m_data  [N];
    int            m_ptr;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [XW-1:0] m_out;

    msrv32_wb_arbiter #(.N_SRC(N), .XLEN(XW), .REG_ADDR_W(AW)) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .src_valid_in   (src_valid_in),
        .src_ready_out  (src_ready_out),
        .src_rd_addr_in (src_rd_addr_in),
        .src_data_in    (src_data_in),
        .wr_en_out      (wr_en_out),
        .rd_addr_out    (rd_addr_out),
        .rd_out         (rd_out),
        .pend_mask_out  (pend_mask_out),
        .idle_out       (idle_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [AW-1:0] rd, input logic [XW-1:0] d);
        src_valid_in[i]           = v;
        src_rd_addr_in[i*AW +: AW] = rd;
        src_data_in[i*XW +: XW]    = d;
    endtask

    task automatic idle_all();
        src_valid_in   = '0;
        src_rd_addr_in = '0;
        src_data_in    = '0;
    endtask

    task automatic do_reset();
        idle_all();
        reset_in = 1'b1;
        cyc();
        reset_in = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (wr_en_out !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", wr_en_out); end
        vectors++; if (rd_addr_out !== 5'd0) begin miscompares++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr_out); end
        vectors++; if (rd_out !== 32'd0) begin miscompares++; $display("FAIL reset_rd_out: got %h want 0", rd_out); end
        vectors++; if (pend_mask_out !== 32'd0) begin miscompares++; $display("FAIL reset_pend: got %h want 0", pend_mask_out); end
        vectors++; if (idle_out !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b want 1", idle_out); end
        vectors++; if (src_ready_out !== 3'b111) begin miscompares++; $display("FAIL reset_ready: got %b want 111", src_ready_out); end
    endtask

    task automatic test_single_write();
        do_reset();
        drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        vectors++; if (src_ready_out[0] !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", src_ready_out[0]); end
        cyc();
        idle_all();
        #1;
        vectors++; if (pend_mask_out !== 32'h20) begin miscompares++; $display("FAIL single_pend_buf: got %h want 20", pend_mask_out); end
        vectors++; if (wr_en_out !== 1'b0) begin miscompares++; $display("FAIL single_wr_early: got %b want 0", wr_en_out); end
        cyc();
        vectors++; if (wr_en_out !== 1'b1) begin miscompares++; $display("FAIL single_wr_en: got %b want 1", wr_en_out); end
        vectors++; if (rd_addr_out !== 5'd5) begin miscompares++; $display("FAIL single_rd_addr: got %0d want 5", rd_addr_out); end
        vectors++; if (rd_out !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_rd_out: got %h want deadbeef", rd_out); end
        vectors++; if (pend_mask_out !== 32'h20) begin miscompares++; $display("FAIL single_pend_out: got %h want 20", pend_mask_out); end
        cyc();
        vectors++; if (pend_mask_out !== 32'h0) begin miscompares++; $display("FAIL single_pend_clear: got %h want 0", pend_mask_out); end
        vectors++; if (idle_out !== 1'b1) begin miscompares++; $display("FAIL single_idle: got %b want 1", idle_out); end
        vectors++; if (wr_en_out !== 1'b0) begin miscompares++; $display("FAIL single_wr_done: got %b want 0", wr_en_out); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] order0 [3];
        logic [AW-1:0] order2 [3];
        order0 = '{5'd1, 5'd2, 5'd3};
        order2 = '{5'd3, 5'd1, 5'd2};
        do_reset();
        for (int i = 0; i < 3; i++) drive(i, 1'b1, AW'(i + 1), 32'h100 + 32'(i));
        #1;
        vectors++; if (src_ready_out !== 3'b111) begin miscompares++; $display("FAIL rr0_ready: got %b want 111", src_ready_out); end
        cyc();
        idle_all();
        #1;
        vectors++; if (wr_en_out !== 1'b0) begin miscompares++; $display("FAIL rr0_latency: got %b want 0", wr_en_out); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            vectors++; if (wr_en_out !== 1'b1 || rd_addr_out !== order0[k]) begin
                miscompares++; $display("FAIL rr0_order%0d: got en=%b rd=%0d want en=1 rd=%0d", k, wr_en_out, rd_addr_out, order0[k]);
            end
        end
        // move the pointer to 2 through a lone write from src1
        drive(1, 1'b1, 5'd4, 32'h44);
        cyc();
        idle_all();
        cyc();
        cyc();
        for (int i = 0; i < 3; i++) drive(i, 1'b1, AW'(i + 1), 32'h200 + 32'(i));
        #1;
        vectors++; if (src_ready_out !== 3'b111) begin miscompares++; $display("FAIL rr2_ready: got %b want 111", src_ready_out); end
        cyc();
        idle_all();
        for (int k = 0; k < 3; k++) begin
            cyc();
            vectors++; if (wr_en_out !== 1'b1 || rd_addr_out !== order2[k]) begin
                miscompares++; $display("FAIL rr2_order%0d: got en=%b rd=%0d want en=1 rd=%0d", k, wr_en_out, rd_addr_out, order2[k]);
            end
        end
    endtask

    task automatic test_x0_discard();
        do_reset();
        drive(1, 1'b1, 5'd0, 32'h1234);
        #1;
        vectors++; if (src_ready_out[1] !== 1'b1) begin miscompares++; $display("FAIL x0_ready: got %b want 1", src_ready_out[1]); end
        cyc();
        idle_all();
        #1;
        vectors++; if (pend_mask_out !== 32'h0 || wr_en_out !== 1'b0) begin
            miscompares++; $display("FAIL x0_buffered: got pend=%h en=%b want 0/0", pend_mask_out, wr_en_out);
        end
        cyc();
        vectors++; if (pend_mask_out !== 32'h0 || wr_en_out !== 1'b0 || idle_out !== 1'b1) begin
            miscompares++; $display("FAIL x0_consumed: got pend=%h en=%b idle=%b want 0/0/1", pend_mask_out, wr_en_out, idle_out);
        end
        // pointer now at 2: src2 must win over src0
        drive(0, 1'b1, 5'd10, 32'hA);
        drive(2, 1'b1, 5'd11, 32'hB);
        cyc();
        idle_all();
        cyc();
        vectors++; if (wr_en_out !== 1'b1 || rd_addr_out !== 5'd11) begin
            miscompares++; $display("FAIL x0_ptr_first: got en=%b rd=%0d want 1/11", wr_en_out, rd_addr_out);
        end
        cyc();
        vectors++; if (wr_en_out !== 1'b1 || rd_addr_out !== 5'd10) begin
            miscompares++; $display("FAIL x0_ptr_second: got en=%b rd=%0d want 1/10", wr_en_out, rd_addr_out);
        end
    endtask

    task automatic test_same_rd();
        do_reset();
        drive(0, 1'b1, 5'd1, 32'h11);
        drive(2, 1'b1, 5'd7, 32'hAAAA);
        cyc();
        idle_all();
        drive(1, 1'b1, 5'd7, 32'hBBBB);
        #1;
        vectors++; if (src_ready_out[1] !== 1'b0) begin miscompares++; $display("FAIL samerd_stall: got %b want 0", src_ready_out[1]); end
        cyc();
        vectors++; if (src_ready_out[1] !== 1'b1) begin miscompares++; $display("FAIL samerd_release: got %b want 1", src_ready_out[1]); end
        cyc();
        idle_all();
        #1;
        vectors++; if (wr_en_out !== 1'b1 || rd_addr_out !== 5'd7 || rd_out !== 32'hAAAA) begin
            miscompares++; $display("FAIL samerd_first: got en=%b rd=%0d d=%h want 1/7/aaaa", wr_en_out, rd_addr_out, rd_out);
        end
        cyc();
        vectors++; if (wr_en_out !== 1'b1 || rd_addr_out !== 5'd7 || rd_out !== 32'hBBBB) begin
            miscompares++; $display("FAIL samerd_second: got en=%b rd=%0d d=%h want 1/7/bbbb", wr_en_out, rd_addr_out, rd_out);
        end
        // same-cycle tie on rd 9
        do_reset();
        drive(0, 1'b1, 5'd9, 32'hC0C0);
        drive(1, 1'b1, 5'd9, 32'hD0D0);
        #1;
        vectors++; if (src_ready_out[1:0] !== 2'b01) begin miscompares++; $display("FAIL tie_ready: got %b want 01", src_ready_out[1:0]); end
        cyc();
        drive(0, 1'b0, 5'd0, 32'h0);
        #1;
        vectors++; if (src_ready_out[1] !== 1'b1) begin miscompares++; $display("FAIL tie_release: got %b want 1", src_ready_out[1]); end
        cyc();
        idle_all();
        #1;
        vectors++; if (wr_en_out !== 1'b1 || rd_addr_out !== 5'd9 || rd_out !== 32'hC0C0) begin
            miscompares++; $display("FAIL tie_first: got en=%b rd=%0d d=%h want 1/9/c0c0", wr_en_out, rd_addr_out, rd_out);
        end
        cyc();
        vectors++; if (wr_en_out !== 1'b1 || rd_addr_out !== 5'd9 || rd_out !== 32'hD0D0) begin
            miscompares++; $display("FAIL tie_second: got en=%b rd=%0d d=%h want 1/9/d0d0", wr_en_out, rd_addr_out, rd_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            if (c < 8) drive(0, 1'b1, AW'(c + 1), 32'hA000_0000 + 32'(c));
            else idle_all();
            #1;
            if (c < 8) begin
                vectors++; if (src_ready_out[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_ready%0d: got %b want 1", c, src_ready_out[0]); end
            end
            if (c >= 2 && c < 10) begin
                vectors++; if (wr_en_out !== 1'b1 || rd_addr_out !== AW'(c - 1) || rd_out !== 32'hA000_0000 + 32'(c - 2)) begin
                    miscompares++; $display("FAIL b2b_out%0d: got en=%b rd=%0d d=%h want 1/%0d/%h",
                                            c, wr_en_out, rd_addr_out, rd_out, c - 1, 32'hA000_0000 + 32'(c - 2));
                end
            end
            if (c == 10) begin
                vectors++; if (wr_en_out !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got %b want 0", wr_en_out); end
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) drive(i, 1'b1, AW'(i + 1), 32'h300 + 32'(i));
        cyc();
        idle_all();
        drive(0, 1'b1, 5'd4, 32'h304);
        cyc();
        idle_all();
        #1;
        vectors++; if (wr_en_out !== 1'b1 || idle_out !== 1'b0) begin
            miscompares++; $display("FAIL mid_busy: got en=%b idle=%b want 1/0", wr_en_out, idle_out);
        end
        reset_in = 1'b1;
        cyc();
        reset_in = 1'b0;
        #1;
        vectors++; if (wr_en_out !== 1'b0 || pend_mask_out !== 32'h0 || idle_out !== 1'b1 || src_ready_out !== 3'b111) begin
            miscompares++; $display("FAIL mid_reset: got en=%b pend=%h idle=%b rdy=%b want 0/0/1/111",
                                    wr_en_out, pend_mask_out, idle_out, src_ready_out);
        end
        drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        vectors++; if (src_ready_out[0] !== 1'b1) begin miscompares++; $display("FAIL mid_after_ready: got %b want 1", src_ready_out[0]); end
        cyc();
        idle_all();
        #1;
        vectors++; if (wr_en_out !== 1'b0) begin miscompares++; $display("FAIL mid_after_quiet: got %b want 0", wr_en_out); end
        cyc();
        vectors++; if (wr_en_out !== 1'b1 || rd_addr_out !== 5'd5 || rd_out !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL mid_after_write: got en=%b rd=%0d d=%h want 1/5/deadbeef", wr_en_out, rd_addr_out, rd_out);
        end
    endtask

    // model: first valid buffer at or after the pointer, -1 if none
    function automatic int m_grant();
        for (int k = 0; k < int'(N); k++) begin
            int idx = (m_ptr + k) % int'(N);
            if (m_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready(input int g);
        logic [N-1:0] r = '0;
        for (int i = 0; i < int'(N); i++) begin
            logic [AW-1:0] a = src_rd_addr_in[i*AW +: AW];
            logic ok = !m_valid[i] || (g == i);
            if (a != 0) begin
                for (int j = 0; j < int'(N); j++)
                    if (j != i && m_valid[j] && g != j && m_rd[j] == a) ok = 1'b0;
                for (int k = 0; k < i; k++)
                    if (src_valid_in[k] && r[k] && src_rd_addr_in[k*AW +: AW] == a) ok = 1'b0;
            end
            r[i] = ok;
        end
        return r;
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        for (int reg_i = 1; reg_i < 32; reg_i++) begin
            if (m_wr && int'(m_addr) == reg_i) p[reg_i] = 1'b1;
            for (int i = 0; i < int'(N); i++)
                if (m_valid[i] && int'(m_rd[i]) == reg_i) p[reg_i] = 1'b1;
        end
        return p;
    endfunction

    task automatic test_random();
        int g;
        logic [N-1:0] r;
        logic any_v;
        do_reset();
        for (int i = 0; i < int'(N); i++) begin m_valid[i] = 1'b0; m_rd[i] = '0; m_data[i] = '0; end
        m_ptr = 0; m_wr = 1'b0; m_addr = '0; m_out = '0;
        for (int cnum = 0; cnum < 400; cnum++) begin
            for (int i = 0; i < int'(N); i++)
                drive(i, $urandom_range(0, 9) < 6, AW'($urandom_range(0, 6)), $urandom);
            #1;
            g = m_grant();
            r = m_ready(g);
            any_v = 1'b0;
            for (int i = 0; i < int'(N); i++) any_v = any_v | m_valid[i];
            vectors++; if (src_ready_out !== r) begin miscompares++; $display("FAIL rnd_ready c%0d: got %b want %b", cnum, src_ready_out, r); end
            vectors++; if (wr_en_out !== m_wr) begin miscompares++; $display("FAIL rnd_wr_en c%0d: got %b want %b", cnum, wr_en_out, m_wr); end
            vectors++; if (rd_addr_out !== m_addr) begin miscompares++; $display("FAIL rnd_rd_addr c%0d: got %0d want %0d", cnum, rd_addr_out, m_addr); end
            vectors++; if (rd_out !== m_out) begin miscompares++; $display("FAIL rnd_rd_out c%0d: got %h want %h", cnum, rd_out, m_out); end
            vectors++; if (pend_mask_out !== m_pend()) begin miscompares++; $display("FAIL rnd_pend c%0d: got %h want %h", cnum, pend_mask_out, m_pend()); end
            vectors++; if (idle_out !== (!any_v && !m_wr)) begin miscompares++; $display("FAIL rnd_idle c%0d: got %b want %b", cnum, idle_out, !any_v && !m_wr); end
            // advance model across the edge: drain grant, then accept new writes
            if (g >= 0) begin
                m_wr      = (m_rd[g] != 0);
                m_addr    = m_rd[g];
                m_out     = m_data[g];
                m_valid[g] = 1'b0;
                m_ptr     = (g + 1) % int'(N);
            end else begin
                m_wr = 1'b0;
            end
            for (int i = 0; i < int'(N); i++) begin
                if (src_valid_in[i] && r[i]) begin
                    m_valid[i] = 1'b1;
                    m_rd[i]    = src_rd_addr_in[i*AW +: AW];
                    m_data[i]  = src_data_in[i*XW +: XW];
                end
            end
            cyc();
        end
        idle_all();
    endtask

    initial begin
        reset_in = 1'b1;
        idle_all();
        test_reset();
        test_single_write();
        test_round_robin();
        test_x0_discard();
        test_same_rd();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
